kpscan: RTL

//  Autonomous 4x4 keypad scan controller for the CMod S6 SoC; replaces software column
//  bit-banging. Drives keypad columns, synchronises and debounces rows, queues key

---
 rtl/kpscan_if.sv | 21 ++
 rtl/kpscan.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kpscan_if.sv
// rtl/kpscan_if.sv - peripheral bus bundle between the bus master and the kpscan controller
interface kpscan_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic        i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/kpscan.sv
// rtl/kpscan.sv - 4x4 keypad scanner with debounce, key-code FIFO and level interrupt
// Optional held-key auto-repeat is built when KPSCAN_REPEAT_EN is defined.
module kpscan #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int DEBOUNCE_LGCYC = 16,
    parameter int LGFIFO         = 3
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    kpscan_if.slave    wb,
    output logic [3:0] o_kp_col,
    input  logic [3:0] i_kp_row,
    output logic       o_kp_int
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam int CW = (DEBOUNCE_LGCYC + 1 > $clog2(SETTLE_CYCLES + 2) + 1) ?
                        DEBOUNCE_LGCYC + 1 : $clog2(SETTLE_CYCLES + 2) + 1;
    localparam logic [CW-1:0]   DB_LAST = CW'((64'd1 << DEBOUNCE_LGCYC) - 64'd1);
    localparam logic [CW-1:0]   ST_LAST = CW'(SETTLE_CYCLES + 1);
    localparam logic [LGFIFO:0] FULL    = (LGFIFO+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DEBNC  = 3'd2,
        REPORT = 3'd3,
        RELSE  = 3'd4
    } state_t;

    state_t          r_state, n_state;
    logic [1:0]      r_col, n_col;
    logic [1:0]      r_rid, n_rid;
    logic [CW-1:0]   r_cnt, n_cnt;
    logic [3:0]      r_row_meta, r_row;
    logic            r_enable;
    logic            push;
`ifdef KPSCAN_REPEAT_EN
    logic [DEBOUNCE_LGCYC+3:0] r_hcnt, n_hcnt;
    logic                      r_repeat;
`endif

    logic [3:0]      mem [DEPTH];
    logic [LGFIFO-1:0] r_wr, r_rd;
    logic [LGFIFO:0] r_count;
    logic            r_ovf;
    logic            accept, key_rd, ctrl_wr, pop, flush, do_push;
    logic [31:0]     rdata;
    logic            unused_wdata;

    function automatic logic [1:0] low_row(input logic [3:0] rows);
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!rows[i]) low_row = 2'(i);
    endfunction

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_row_meta <= 4'hf;
            r_row      <= 4'hf;
        end else begin
            r_row_meta <= i_kp_row;
            r_row      <= r_row_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_col   <= 2'd0;
            r_rid   <= 2'd0;
            r_cnt   <= '0;
`ifdef KPSCAN_REPEAT_EN
            r_hcnt  <= '0;
`endif
        end else begin
            r_state <= n_state;
            r_col   <= n_col;
            r_rid   <= n_rid;
            r_cnt   <= n_cnt;
`ifdef KPSCAN_REPEAT_EN
            r_hcnt  <= n_hcnt;
`endif
        end
    end

    always_comb begin
        n_state = r_state;
        n_col   = r_col;
        n_rid   = r_rid;
        n_cnt   = r_cnt;
        push    = 1'b0;
`ifdef KPSCAN_REPEAT_EN
        n_hcnt  = '0;
`endif
        if (!r_enable) begin
            n_state = IDLE;
            n_col   = 2'd0;
            n_cnt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    n_cnt = '0;
                    if (r_row != 4'hf) begin
                        n_state = SCAN;
                        n_col   = 2'd0;
                    end
                end
                SCAN: begin
                    // The extra two cycles cover the row synchroniser latency.
                    if (r_cnt == ST_LAST) begin
                        n_cnt = '0;
                        if (r_row != 4'hf) begin
                            n_state = DEBNC;
                            n_rid   = low_row(r_row);
                        end else if (r_col == 2'd3) begin
                            n_state = IDLE;
                        end else begin
                            n_col = r_col + 2'd1;
                        end
                    end else begin
                        n_cnt = r_cnt + 1'b1;
                    end
                end
                DEBNC: begin
                    if (r_row == 4'hf || low_row(r_row) != r_rid) begin
                        n_state = SCAN;
                        n_col   = 2'd0;
                        n_cnt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        n_state = REPORT;
                        n_cnt   = '0;
                    end else begin
                        n_cnt = r_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    push    = 1'b1;
                    n_state = RELSE;
                    n_cnt   = '0;
                end
                RELSE: begin
                    if (r_row != 4'hf) begin
                        n_cnt = '0;
`ifdef KPSCAN_REPEAT_EN
                        n_hcnt = r_hcnt + 1'b1;
                        if (r_repeat && (&r_hcnt)) begin
                            n_state = SCAN;
                            n_col   = 2'd0;
                            n_hcnt  = '0;
                        end
`endif
                    end else if (r_cnt == DB_LAST) begin
                        n_state = IDLE;
                        n_cnt   = '0;
                    end else begin
                        n_cnt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    n_state = IDLE;
                    n_cnt   = '0;
                end
            endcase
        end
    end

    assign o_kp_col = (r_enable && (r_state == SCAN || r_state == DEBNC)) ?
                      ~(4'b0001 << r_col) : 4'h0;

    assign accept  = wb.i_wb_cyc & wb.i_wb_stb;
    assign key_rd  = accept & ~wb.i_wb_we & ~wb.i_wb_addr;
    assign ctrl_wr = accept & wb.i_wb_we & wb.i_wb_addr;
    assign flush   = ctrl_wr & wb.i_wb_data[1];
    assign pop     = key_rd && (r_count != '0) && !flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && !flush && (r_count != FULL || pop);
    assign unused_wdata = ^wb.i_wb_data[31:2];

    always_ff @(posedge i_clk) begin
        if (do_push) mem[r_wr] <= {r_rid, r_col};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (do_push) r_wr <= r_wr + 1'b1;
            if (pop)     r_rd <= r_rd + 1'b1;
            case ({do_push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (push && r_count == FULL && !pop) r_ovf <= 1'b1;
            else if (key_rd)                     r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_enable <= 1'b1;
`ifdef KPSCAN_REPEAT_EN
            r_repeat <= 1'b1;
`endif
        end else if (ctrl_wr) begin
            r_enable <= wb.i_wb_data[0];
`ifdef KPSCAN_REPEAT_EN
            r_repeat <= wb.i_wb_data[2];
`endif
        end
    end

    always_comb begin
        rdata = '0;
        if (!wb.i_wb_addr) begin
            rdata[3:0]          = (r_count != '0) ? mem[r_rd] : 4'h0;
            rdata[4]            = (r_count != '0);
            rdata[5]            = r_ovf;
            rdata[LGFIFO+8:8]   = r_count;
        end else begin
            rdata[0] = r_enable;
`ifdef KPSCAN_REPEAT_EN
            rdata[2] = r_repeat;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wb.o_wb_ack  <= 1'b0;
            wb.o_wb_data <= '0;
            o_kp_int     <= 1'b0;
        end else begin
            wb.o_wb_ack <= accept;
            if (accept) wb.o_wb_data <= rdata;
            o_kp_int    <= (r_count != '0);
        end
    end

    assign wb.o_wb_stall = 1'b0;
endmodule
